gpio_edge_avalon: RTL



---
 rtl/gpio_edge_avalon.sv | 127 ++++++++++++
 1 files changed

// File: rtl/gpio_edge_avalon.sv
// Avalon-MM GPIO slave: synchronised and debounced inputs, sticky rising-edge
// capture with a maskable level interrupt, and a software-written output register.
module gpio_edge_avalon #(
  parameter int WIDTH      = 10,
  parameter int DEB_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out
);

  localparam int            CW        = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_OUT     = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [WIDTH-1:0] filt_q, filt_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] rise;

  // Upper writedata bits beyond WIDTH carry no meaning for this block.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  assign wr_data = writedata[WIDTH-1:0];

  // Input path: two-flop synchroniser feeding a per-bit debounce counter.
  always_comb begin
    s1_d = gpio_in;
    s2_d = s1_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i]  = '0;
      filt_d[i] = filt_q[i];
      if (s2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          filt_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  // Register writes; a rising edge in the same cycle as its W1C keeps the bit set.
  always_comb begin
    out_d    = out_q;
    mask_d   = mask_q;
    edge_clr = '0;
    if (write) begin
      unique case (address)
        ADDR_DATA,
        ADDR_OUT:     out_d    = wr_data;
        ADDR_IRQMASK: mask_d   = wr_data;
        ADDR_EDGECAP: edge_clr = wr_data;
        default:      out_d    = out_q;
      endcase
    end
    rise   = filt_d & ~filt_q;
    edge_d = (edge_q & ~edge_clr) | rise;
  end

  // Read data reflects pre-write register values and returns to 0 when idle.
  always_comb begin
    rdata_d = '0;
    if (read) begin
      unique case (address)
        ADDR_DATA:    rdata_d[WIDTH-1:0] = filt_q;
        ADDR_OUT:     rdata_d[WIDTH-1:0] = out_q;
        ADDR_IRQMASK: rdata_d[WIDTH-1:0] = mask_q;
        ADDR_EDGECAP: rdata_d[WIDTH-1:0] = edge_q;
        default:      rdata_d            = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      filt_q  <= '0;
      out_q   <= '0;
      mask_q  <= '0;
      edge_q  <= '0;
      rdata_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      filt_q  <= filt_d;
      out_q   <= out_d;
      mask_q  <= mask_d;
      edge_q  <= edge_d;
      rdata_q <= rdata_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign readdata = rdata_q;
  assign gpio_out = out_q;
  assign irq      = |(edge_q & mask_q);

endmodule
